isqrt_rr_arbiter: RTL and testbench
===================================

// Module: isqrt_rr_arbiter
// PURPOSE
//  Shares one pipelined isqrt instance among N_REQ requesters, e.g. several
//  formula FSMs in the sqrt-formula exercises. Issues at most one argument
//  per cycle, chosen round-robin. Tracks every in-flight operation with a
//  tag FIFO and routes each isqrt result back to the requester that issued it.
//  Sits between the formula FSMs and a single isqrt datapath; that isqrt
//  returns results in issue order.
// PARAMETERS
//  N_REQ         4   number of requesters (2..8)
//  MAX_INFLIGHT  8   tag FIFO depth = max outstanding isqrt ops (power of 2)
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  rst          in   1          synchronous reset, active-high
//  req_vld      in   N_REQ      requester i has an argument pending
//  req_arg      in   N_REQ*32   argument of requester i in bits [32*i +: 32]
//  req_gnt      out  N_REQ      one-hot; argument i accepted this cycle
//  rsp_vld      out  N_REQ      one-hot; result for requester i on rsp_res
//  rsp_res      out  16         result, shared by all requesters
//  isqrt_x_vld  out  1          argument valid to isqrt
//  isqrt_x      out  32         argument to isqrt
//  isqrt_y_vld  in   1          result valid from isqrt
//  isqrt_y      in   16         result from isqrt
//  inflight     out  $clog2(MAX_INFLIGHT+1)  outstanding op count
//  err          out  1          sticky: isqrt_y_vld arrived with empty tag FIFO
// BEHAVIOUR
//  Reset: req_gnt=0, rsp_vld=0, rsp_res=0, isqrt_x_vld=0, isqrt_x=0,
//   inflight=0, err=0. Tag FIFO emptied. RR pointer set so requester 0 has
//   top priority. isqrt shares the same rst. Any op in flight is discarded;
//   nothing is replayed after reset.
//  Grant (combinational, cycle t): the grant is enabled when inflight < MAX_INFLIGHT.
//   The winner is the first i with req_vld[i], scanning from (last_winner+1) mod
//   N_REQ upward with wrap. req_gnt is one-hot or zero. No grant when disabled.
//   A requester holds req_vld/req_arg stable until it sees its req_gnt.
//  Issue (registered): isqrt_x_vld=1 and isqrt_x=winner arg in cycle t+1,
//   otherwise isqrt_x_vld=0 and isqrt_x holds its last value. The winner's
//   index is pushed into the tag FIFO at the edge ending t. last_winner is
//   updated only on a grant.
//  Return: on isqrt_y_vld, pop tag k. In the next cycle rsp_vld = one-hot(k)
//   and rsp_res = isqrt_y, for one cycle only. Total latency from
//   req_gnt to rsp_vld = isqrt latency + 2 cycles.
//  inflight: +1 on grant, -1 on isqrt_y_vld. A grant and a return in the
//   same cycle leave it unchanged. A return at inflight==MAX_INFLIGHT
//   does not enable a grant in that same cycle.
//  isqrt_y_vld with empty FIFO: no pop, rsp_vld stays 0, inflight stays 0,
//   err<=1. err holds until rst.
//  FIFO pointers wrap modulo MAX_INFLIGHT. Full/empty come from inflight.
//  A requester may issue back-to-back; consecutive grants to the same i
//   occur only when no other req_vld is set.
// TESTING
//  T1 single: req_vld=0001, arg=16 -> req_gnt[0] at t; isqrt_x=16 at t+1;
//     rsp_vld=0001, rsp_res=4 at isqrt latency+2; inflight returns to 0.
//  T2 RR fairness: req_vld=1111 held, args 4,9,25,49 -> grants in order
//     0,1,2,3,0...; rsp_res sequence 2,3,5,7 on rsp_vld 0001,0010,0100,1000.
//  T3 full: freeze isqrt_y_vld, 9 continuous requests -> exactly 8 grants,
//     inflight=8, req_gnt=0; after the first isqrt_y_vld, grant resumes the
//     following cycle.
//  T4 simultaneous: a grant and a return in the same cycle at inflight=3
//     -> inflight stays 3; the return is routed to the correct tag.
//  T5 spurious: isqrt_y_vld pulse with inflight=0 -> err=1, rsp_vld=0;
//     err stays set until rst.
//  T6 reset mid-op: rst while inflight=5 -> next cycle all outputs at reset
//     values; new request after reset gets correct rsp with err=0.

Source files
------------

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end that shares one in-order pipelined isqrt among N_REQ
// requesters; a tag FIFO remembers who issued each op so results route back.
module isqrt_rr_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_vld,
  input  logic [N_REQ*32-1:0]               req_arg,
  output logic [N_REQ-1:0]                  req_gnt,
  output logic [N_REQ-1:0]                  rsp_vld,
  output logic [15:0]                       rsp_res,
  output logic                              isqrt_x_vld,
  output logic [31:0]                       isqrt_x,
  input  logic                              isqrt_y_vld,
  input  logic [15:0]                       isqrt_y,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT+1);

  // Handshake: requester i raises req_vld[i] with req_arg stable and keeps both
  // until the cycle req_gnt[i] is high; that cycle's edge consumes the argument.
  // The isqrt side has no back-pressure: isqrt_x_vld is a one-cycle push and
  // isqrt_y_vld a one-cycle in-order return.

  logic [IW-1:0] last_winner;
  logic [IW-1:0] win_idx;
  logic          gnt_en;
  logic          gnt_any;
  logic          pop;
  logic [IW-1:0] tag_mem [MAX_INFLIGHT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Scan from farthest to nearest so the nearest requester after last_winner
  // is the final assignment and therefore the winner.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_en  = (inflight < CW'(MAX_INFLIGHT));
    gnt_any = 1'b0;
    win_idx = last_winner;
    req_gnt = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(last_winner) + off) % N_REQ;
      if (req_vld[IW'(cand)]) begin
        gnt_any = gnt_en;
        win_idx = IW'(cand);
      end
    end
    if (gnt_any) req_gnt[win_idx] = 1'b1;
  end

  // A return with nothing outstanding is spurious and must not disturb the FIFO.
  assign pop = isqrt_y_vld && (inflight != '0);

  always_ff @(posedge clk) begin
    if (gnt_any) tag_mem[wr_ptr] <= win_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= IW'(N_REQ - 1);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      rsp_vld     <= '0;
      rsp_res     <= '0;
      inflight    <= '0;
      err         <= 1'b0;
    end else begin
      isqrt_x_vld <= gnt_any;
      if (gnt_any) begin
        isqrt_x     <= req_arg[win_idx*32 +: 32];
        wr_ptr      <= wr_ptr + PW'(1);
        last_winner <= win_idx;
      end

      rsp_vld <= '0;
      if (pop) begin
        rsp_vld[tag_mem[rd_ptr]] <= 1'b1;
        rsp_res                  <= isqrt_y;
        rd_ptr                   <= rd_ptr + PW'(1);
      end

      if (isqrt_y_vld && (inflight == '0)) err <= 1'b1;

      case ({gnt_any, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: in-bench isqrt stub, queue-based arbiter model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_isqrt_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXF = 8;
  localparam int L    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_vld;
  logic [N*32-1:0] req_arg;
  logic [N-1:0]  req_gnt;
  logic [N-1:0]  rsp_vld;
  logic [15:0]   rsp_res;
  logic          isqrt_x_vld;
  logic [31:0]   isqrt_x;
  logic          isqrt_y_vld;
  logic [15:0]   isqrt_y;
  logic [3:0]    inflight;
  logic          err;

  always #5 clk = ~clk;

  isqrt_rr_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_arg(req_arg),
    .req_gnt(req_gnt), .rsp_vld(rsp_vld), .rsp_res(rsp_res),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .inflight(inflight), .err(err)
  );

  typedef struct { logic [15:0] y; int due; } pend_t;

  pend_t       pend_q[$];
  logic [31:0] rq [N][$];
  logic [18:0] exp_q[$];
  int          m_last, m_infl;
  bit          m_err, m_xv;
  logic [31:0] m_x;
  logic [3:0]  m_rsp;
  logic [15:0] m_res;
  bit          freeze, spur, rst_req;
  int          cyc;
  int          n_checks, n_fail;
  int          gnt_cyc[$], gnt_idx[$], rsp_cyc[$], ycyc[$];
  logic [19:0] rsp_log[$];

  function automatic logic [15:0] isqrt_f(logic [31:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 16'(r);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (m_infl >= MAXF) return -1;
    for (int off = 1; off <= N; off++) begin
      automatic int i = (m_last + off) % N;
      if (rq[i].size() != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_infl = 0; m_err = 0; m_xv = 0;
    m_x = '0; m_rsp = '0; m_res = '0;
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic clear_logs();
    gnt_cyc.delete(); gnt_idx.delete(); rsp_cyc.delete(); ycyc.delete(); rsp_log.delete();
  endtask

  // One clock: drive inputs at negedge, compare just after, then advance model.
  task automatic step();
    int g;
    logic [3:0]  eg;
    logic [18:0] e;
    @(negedge clk);
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      req_vld[i]          = (rq[i].size() != 0);
      req_arg[32*i +: 32] = (rq[i].size() != 0) ? rq[i][0] : 32'd0;
    end
    isqrt_y_vld = 1'b0;
    isqrt_y     = '0;
    if (rst_req) pend_q.delete();
    else if (spur) begin
      isqrt_y_vld = 1'b1; isqrt_y = 16'hbeef; spur = 0;
    end else if (!freeze && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      isqrt_y_vld = 1'b1; isqrt_y = pend_q[0].y;
      void'(pend_q.pop_front());
      ycyc.push_back(cyc);
    end
    #1;
    if (rst) model_reset();
    else begin
      g  = pick();
      eg = (g >= 0) ? 4'(1 << g) : 4'b0;
      check("req_gnt", 32'(req_gnt), 32'(eg));
      check("isqrt_x_vld", 32'(isqrt_x_vld), 32'(m_xv));
      check("isqrt_x", isqrt_x, m_x);
      check("rsp_vld", 32'(rsp_vld), 32'(m_rsp));
      check("rsp_res", 32'(rsp_res), 32'(m_res));
      check("inflight", 32'(inflight), 32'(m_infl));
      check("err", 32'(err), 32'(m_err));
      if (rsp_vld != '0) begin
        rsp_log.push_back({rsp_vld, rsp_res});
        rsp_cyc.push_back(cyc);
      end
      m_rsp = '0;
      if (isqrt_y_vld) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          m_rsp = 4'(1 << e[18:16]);
          m_res = e[15:0];
          m_infl--;
        end else m_err = 1;
      end
      m_xv = (g >= 0);
      if (g >= 0) begin
        m_x = rq[g][0];
        exp_q.push_back({3'(g), isqrt_f(rq[g][0])});
        m_last = g;
        m_infl++;
        void'(rq[g].pop_front());
        gnt_cyc.push_back(cyc);
        gnt_idx.push_back(g);
      end
      if (isqrt_x_vld) pend_q.push_back(pend_t'{isqrt_f(isqrt_x), cyc + L});
    end
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_req = 1; step(); rst_req = 0;
    for (int i = 0; i < N; i++) rq[i].delete();
    freeze = 0; spur = 0;
    clear_logs();
  endtask

  function automatic logic [19:0] rsp_at(int k);
    return (rsp_log.size() > k) ? rsp_log[k] : 20'hfffff;
  endfunction

  function automatic int gidx_at(int k);
    return (gnt_idx.size() > k) ? gnt_idx[k] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[5];
    logic [19:0] exp_r[4];
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; req_vld = '0; req_arg = '0; isqrt_y_vld = 1'b0; isqrt_y = '0;
    freeze = 0; spur = 0; rst_req = 1;
    model_reset();
    step(); step();
    rst_req = 0;
    step();
    check("reset_inflight", 32'(inflight), 0);
    check("reset_err", 32'(err), 0);
    check("reset_rsp_vld", 32'(rsp_vld), 0);
    check("reset_x_vld", 32'(isqrt_x_vld), 0);

    // T1 single request
    do_reset();
    rq[0].push_back(32'd16);
    run(12);
    check("t1_gnt_count", gnt_idx.size(), 1);
    check("t1_gnt_idx", gidx_at(0), 0);
    check("t1_rsp", rsp_at(0), {4'b0001, 16'd4});
    check("t1_latency", (rsp_cyc.size() > 0 && gnt_cyc.size() > 0) ? rsp_cyc[0] - gnt_cyc[0] : -1, L + 2);
    check("t1_inflight", 32'(inflight), 0);

    // T2 round-robin fairness
    do_reset();
    for (int r = 0; r < 2; r++) begin
      rq[0].push_back(32'd4); rq[1].push_back(32'd9);
      rq[2].push_back(32'd25); rq[3].push_back(32'd49);
    end
    run(20);
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) check("t2_gnt_order", gidx_at(k), exp_g[k]);
    exp_r = '{{4'b0001, 16'd2}, {4'b0010, 16'd3}, {4'b0100, 16'd5}, {4'b1000, 16'd7}};
    for (int k = 0; k < 4; k++) check("t2_rsp", rsp_at(k), exp_r[k]);

    // T3 FIFO full, then resume after first return
    do_reset();
    freeze = 1;
    for (int k = 1; k <= 9; k++) rq[1].push_back(32'(100 + k));
    run(12);
    check("t3_gnt_count", gnt_idx.size(), 8);
    check("t3_inflight", 32'(inflight), 8);
    check("t3_req_gnt", 32'(req_gnt), 0);
    freeze = 0;
    run(20);
    check("t3_gnt_total", gnt_idx.size(), 9);
    check("t3_resume", (gnt_cyc.size() > 8 && ycyc.size() > 0) ? gnt_cyc[8] - ycyc[0] : -1, 1);
    check("t3_drained", 32'(inflight), 0);

    // T4 grant and return in the same cycle at inflight=3
    do_reset();
    freeze = 1;
    rq[0].push_back(32'd1); rq[0].push_back(32'd4); rq[0].push_back(32'd9);
    run(6);
    check("t4_pre_inflight", 32'(inflight), 3);
    freeze = 0;
    rq[2].push_back(32'd100);
    step();
    freeze = 1;
    step();
    check("t4_inflight", 32'(inflight), 3);
    check("t4_same_cycle", (gnt_cyc.size() > 3 && ycyc.size() > 0) ? gnt_cyc[3] - ycyc[0] : -1, 0);
    check("t4_rsp_vld", 32'(rsp_vld), 32'b0001);
    check("t4_rsp_res", 32'(rsp_res), 1);
    freeze = 0;
    run(15);
    exp_r = '{{4'b0001, 16'd1}, {4'b0001, 16'd2}, {4'b0001, 16'd3}, {4'b0100, 16'd10}};
    for (int k = 0; k < 4; k++) check("t4_rsp", rsp_at(k), exp_r[k]);

    // T5 spurious return
    do_reset();
    spur = 1;
    step(); step();
    check("t5_err", 32'(err), 1);
    check("t5_rsp_vld", 32'(rsp_vld), 0);
    check("t5_inflight", 32'(inflight), 0);
    run(5);
    check("t5_err_sticky", 32'(err), 1);

    // T6 reset with ops in flight
    do_reset();
    freeze = 1;
    rq[0].push_back(32'd1); rq[0].push_back(32'd2);
    rq[1].push_back(32'd3); rq[2].push_back(32'd4); rq[3].push_back(32'd5);
    run(7);
    check("t6_pre_inflight", 32'(inflight), 5);
    rst_req = 1; step(); rst_req = 0;
    step();
    check("t6_req_gnt", 32'(req_gnt), 0);
    check("t6_rsp_vld", 32'(rsp_vld), 0);
    check("t6_rsp_res", 32'(rsp_res), 0);
    check("t6_x_vld", 32'(isqrt_x_vld), 0);
    check("t6_x", isqrt_x, 0);
    check("t6_inflight", 32'(inflight), 0);
    check("t6_err", 32'(err), 0);
    freeze = 0;
    clear_logs();
    rq[3].push_back(32'd81);
    run(12);
    check("t6_rsp_count", rsp_log.size(), 1);
    check("t6_rsp", rsp_at(0), {4'b1000, 16'd9});
    check("t6_err_after", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
